// File: rtl/unary_stream_collector_if.sv
// Handshake/status bundle between the unary stream collector and its neighbours.
interface unary_stream_collector_if #(
  parameter int COUNT_WIDTH = 6
);
  logic                   y_in;
  logic                   in_valid;
  logic                   clear;
  logic [COUNT_WIDTH-1:0] result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   frame_done;
  logic                   busy;
  logic                   overrun;
  logic                   timeout;

  modport slave (
    input  y_in, in_valid, clear, result_ready,
    output result, result_valid, frame_done, busy, overrun, timeout
  );

  modport master (
    output y_in, in_valid, clear, result_ready,
    input  result, result_valid, frame_done, busy, overrun, timeout
  );
endinterface

// File: rtl/unary_stream_collector.sv
// Collects INPUT_WIDTH valid unary bits per frame and presents the ones-count behind a valid/ready register.
// Optional mid-frame idle timeout enabled by defining UNARY_COLLECT_TIMEOUT_EN.
module unary_stream_collector #(
  parameter int INPUT_WIDTH    = 32,
  parameter int COUNT_WIDTH    = $clog2(INPUT_WIDTH + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  unary_stream_collector_if.slave bus
);

  typedef enum logic {ACC_IDLE, ACC_ACCUM} acc_state_t;
  typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(INPUT_WIDTH - 1);

  function automatic logic [COUNT_WIDTH-1:0] add_bit(input logic [COUNT_WIDTH-1:0] cnt,
                                                     input logic                   b);
    return cnt + COUNT_WIDTH'(b);
  endfunction

  acc_state_t             acc_q, acc_d;
  out_state_t             out_q, out_d;
  logic [COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [COUNT_WIDTH-1:0] ones_cnt_q, ones_cnt_d;
  logic [COUNT_WIDTH-1:0] result_q, result_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic [COUNT_WIDTH-1:0] final_cnt;
  logic                   accept;

`ifdef UNARY_COLLECT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  assign final_cnt = add_bit(ones_cnt_q, bus.y_in);
  assign accept    = (out_q == OUT_HOLD) && bus.result_ready;

  always_comb begin
    acc_d        = acc_q;
    out_d        = out_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    result_d     = result_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
`ifdef UNARY_COLLECT_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = timeout_q;
`endif
    if (bus.clear) begin
      // Abort wins over everything; the stale result value is kept but no longer valid.
      acc_d      = ACC_IDLE;
      out_d      = OUT_EMPTY;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
      overrun_d  = 1'b0;
`ifdef UNARY_COLLECT_TIMEOUT_EN
      idle_cnt_d = '0;
      timeout_d  = 1'b0;
`endif
    end else begin
      if (accept) out_d = OUT_EMPTY;
      if (bus.in_valid) begin
`ifdef UNARY_COLLECT_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (bit_cnt_q == LAST_BIT) begin
          acc_d        = ACC_IDLE;
          bit_cnt_d    = '0;
          ones_cnt_d   = '0;
          frame_done_d = 1'b1;
          // A consumer draining the register this very cycle frees it for the new frame.
          if ((out_q == OUT_EMPTY) || accept) begin
            result_d = final_cnt;
            out_d    = OUT_HOLD;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          acc_d      = ACC_ACCUM;
          bit_cnt_d  = bit_cnt_q + COUNT_WIDTH'(1);
          ones_cnt_d = final_cnt;
        end
      end
`ifdef UNARY_COLLECT_TIMEOUT_EN
      else if (acc_q == ACC_ACCUM) begin
        if (idle_cnt_q == IDLE_LAST) begin
          acc_d      = ACC_IDLE;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
          idle_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= ACC_IDLE;
      out_q        <= OUT_EMPTY;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      result_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      out_q        <= out_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      result_q     <= result_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef UNARY_COLLECT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  // Constant-false compare keeps the timeout limit referenced when the feature is compiled out.
  assign bus.timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign bus.result       = result_q;
  assign bus.result_valid = (out_q == OUT_HOLD);
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = (acc_q == ACC_ACCUM);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_unary_stream_collector.sv
// Randomised + directed bench for unary_stream_collector with a frame-level reference model and result scoreboard.
module tb_unary_stream_collector;
  localparam int IW = 8;
  localparam int CW = $clog2(IW + 1);
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  unary_stream_collector_if #(.COUNT_WIDTH(CW)) bus ();

  unary_stream_collector #(
    .INPUT_WIDTH(IW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current frame, output-register occupancy, sticky flags.
  int m_bits[$];
  int m_idle = 0;
  bit m_occ = 1'b0;
  bit m_fd = 1'b0;
  bit m_ovr = 1'b0;
  bit m_to = 1'b0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bits.delete(); exp_q.delete();
      m_idle = 0; m_occ = 0; m_fd = 0; m_ovr = 0; m_to = 0;
    end else begin
      bit drained;
      drained = m_occ && bus.result_ready;
      m_fd = 0;
      if (bus.clear) begin
        if (m_occ && !bus.result_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        m_bits.delete();
        m_idle = 0; m_occ = 0; m_ovr = 0; m_to = 0;
      end else begin
        if (drained) m_occ = 0;
        if (bus.in_valid) begin
          m_idle = 0;
          m_bits.push_back(int'(bus.y_in));
          if (m_bits.size() == IW) begin
            int ones;
            ones = 0;
            foreach (m_bits[k]) ones += m_bits[k];
            m_bits.delete();
            m_fd = 1;
            if (!m_occ) begin
              exp_q.push_back(ones);
              m_occ = 1;
            end else begin
              m_ovr = 1;
            end
          end
        end
`ifdef UNARY_COLLECT_TIMEOUT_EN
        else if (m_bits.size() > 0) begin
          m_idle++;
          if (m_idle == TO) begin
            m_bits.delete();
            m_idle = 0;
            m_to = 1;
          end
        end
`endif
      end
    end
  end

  // Monitor: per-cycle status compare and result scoreboard on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_result", int'(bus.result), 0);
      chk("rst_result_valid", int'(bus.result_valid), 0);
      chk("rst_frame_done", int'(bus.frame_done), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_timeout", int'(bus.timeout), 0);
    end else begin
      chk("result_valid", int'(bus.result_valid), int'(m_occ));
      chk("frame_done", int'(bus.frame_done), int'(m_fd));
      chk("busy", int'(bus.busy), int'(m_bits.size() != 0));
      chk("overrun", int'(bus.overrun), int'(m_ovr));
      chk("timeout", int'(bus.timeout), int'(m_to));
      if (bus.result_valid && bus.result_ready) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else chk("result", int'(bus.result), exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.in_valid = 1'b1;
    bus.y_in = b;
    cyc();
    bus.in_valid = 1'b0;
    bus.y_in = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    bus.y_in = 1'b1;
    repeat (n) cyc();
    bus.y_in = 1'b0;
  endtask

  task automatic send_frame(input logic [IW-1:0] bits);
    for (int i = 0; i < IW; i++) send_bit(bits[i]);
  endtask

  task automatic pulse_clear(input logic with_valid);
    bus.clear = 1'b1;
    bus.in_valid = with_valid;
    bus.y_in = 1'b1;
    cyc();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.y_in = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] fr;
    bus.y_in = 1'b0; bus.in_valid = 1'b0; bus.clear = 1'b0; bus.result_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: basic frame, ones=4
    bus.result_ready = 1'b1;
    fr = 8'b0010_1101;
    send_frame(fr);
    gap(3);

    // 2: frame with gaps carrying y_in=1
    fr = 8'b1001_0110;
    for (int i = 0; i < IW; i++) begin
      send_bit(fr[i]);
      gap(2);
    end
    gap(2);

    // 3: back-pressure, second frame dropped
    bus.result_ready = 1'b0;
    fr = 8'b0000_0111; send_frame(fr);
    fr = 8'b0111_1111; send_frame(fr);
    gap(2);
    bus.result_ready = 1'b1;
    gap(3);
    pulse_clear(1'b0);

    // 4: new frame completes in the cycle the old result is taken
    bus.result_ready = 1'b0;
    fr = 8'b0001_0001; send_frame(fr);
    fr = 8'b1110_1101;
    for (int i = 0; i < IW - 1; i++) send_bit(fr[i]);
    bus.result_ready = 1'b1;
    send_bit(fr[IW-1]);
    gap(3);

    // 5: clear mid-frame, then full-ones frame, then reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    pulse_clear(1'b1);
    fr = 8'hFF; send_frame(fr);
    gap(2);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    gap(1);

    // 6: idle timeout window
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    gap(TO);
    gap(2);
    fr = 8'b1010_1011; send_frame(fr);
    gap(3);
    pulse_clear(1'b0);

    // Randomised traffic with occasional clears and long idle bursts
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 250) begin
        gap(TO + 4);
      end else begin
        bus.result_ready = ($urandom_range(0, 1) == 1);
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.y_in         = $urandom_range(0, 1) == 1;
        bus.clear        = ($urandom_range(0, 255) == 0);
        cyc();
        bus.clear = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.result_ready = 1'b1;
    gap(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
